// File: rtl/cic_result_mem_pkg.sv
// Shared definitions for the CONV engine result memory: bank select codes,
// bank depths, error codes and the tracking state machine encoding.
package cic_result_mem_pkg;

    localparam int unsigned CIC_DW       = 20;
    localparam int unsigned CIC_AW       = 12;
    localparam int unsigned CIC_L0_DEPTH = 4096;   // 64x64 conv output
    localparam int unsigned CIC_L1_DEPTH = 1024;   // 32x32 after max-pool
    localparam int unsigned CIC_L2_DEPTH = 2048;   // interleaved flatten
    localparam int unsigned NUM_BANKS    = 5;
    localparam int unsigned CLEAR_LEN    = 4096;   // written-bit sweep length

    typedef enum logic [2:0] {
        SEL_NSEL = 3'd0,
        SEL_L0K0 = 3'd1,
        SEL_L0K1 = 3'd2,
        SEL_L1K0 = 3'd3,
        SEL_L1K1 = 3'd4,
        SEL_L2F  = 3'd5
    } cic_sel_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_WR_SEL  = 3'd1,
        ERR_WR_ADDR = 3'd2,
        ERR_RD_SEL  = 3'd3,
        ERR_RD_ADDR = 3'd4
    } cic_err_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } cic_state_e;

    // True for the five real banks; NSEL and codes 6-7 are not backed by memory.
    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel >= SEL_L0K0) && (sel <= SEL_L2F);
    endfunction

endpackage

// File: rtl/cic_result_mem_if.sv
// Engine result-memory bus plus the host readback port.
interface cic_result_mem_if
    import cic_result_mem_pkg::*;
#(
    parameter int unsigned DW = CIC_DW,
    parameter int unsigned AW = CIC_AW
);
    logic [2:0]    csel;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          h_req;
    logic [2:0]    h_sel;
    logic [AW-1:0] h_addr;
    logic          h_gnt;
    logic          h_valid;
    logic [DW-1:0] h_data;

    modport master (
        output csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, h_req, h_sel, h_addr,
        input  cdata_rd, h_gnt, h_valid, h_data
    );

    modport slave (
        input  csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd, h_req, h_sel, h_addr,
        output cdata_rd, h_gnt, h_valid, h_data
    );

endinterface

// File: rtl/cic_result_mem_bank.sv
// One result bank: single write port, engine and host read ports with
// registered outputs, plus the per-address written bits and fill counter.
module cic_bank #(
    parameter int unsigned DW    = 20,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned BW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          clr_en,
    input  logic [BW-1:0] clr_idx,
    input  logic          cnt_clr,
    input  logic          cnt_en,
    input  logic          wr_en,
    input  logic [BW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [BW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    input  logic          hrd_en,
    input  logic [BW-1:0] hrd_addr,
    output logic [DW-1:0] hrd_data,
    output logic          full
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic          written [DEPTH];
    logic [DW-1:0] rd_data_reg;
    logic [DW-1:0] hrd_data_reg;
    logic [CW-1:0] count_reg;
    logic          full_reg;
    logic          first_wr;

    // Only a counted write to a never-written address advances the fill count.
    assign first_wr = wr_en & cnt_en & ~written[wr_addr];

    // Data array write; contents survive reset and h_clr.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Engine read port; read-before-write on a colliding address.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data_reg <= mem[rd_addr];
    end

    // Host read port.
    always_ff @(posedge clk) begin
        if (hrd_en) hrd_data_reg <= mem[hrd_addr];
    end

    // Written bits: swept to zero one index per cycle while clearing.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            written[clr_idx] <= 1'b0;
        end else if (first_wr) begin
            written[wr_addr] <= 1'b1;
        end
    end

    // Fill counter and full flag; the flag trails the counter by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else if (cnt_clr) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else begin
            if (first_wr) count_reg <= count_reg + CW'(1);
            full_reg <= run & (count_reg == CW'(DEPTH));
        end
    end

    assign rd_data  = rd_data_reg;
    assign hrd_data = hrd_data_reg;
    assign full     = full_reg;

endmodule

// File: rtl/cic_result_mem.sv
// Result-memory responder: bank decode, engine/host arbitration, sticky
// error capture and the CLEAR/RUN written-bit tracking state machine.
module cic_result_mem
    import cic_result_mem_pkg::*;
#(
    parameter int unsigned DW       = CIC_DW,
    parameter int unsigned AW       = CIC_AW,
    parameter int unsigned L0_DEPTH = CIC_L0_DEPTH,
    parameter int unsigned L1_DEPTH = CIC_L1_DEPTH,
    parameter int unsigned L2_DEPTH = CIC_L2_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    cic_result_mem_if.slave      bus,
    input  logic                 h_clr,
    output logic [NUM_BANKS-1:0] bank_full,
    output logic                 all_full,
    output logic                 err,
    output logic [2:0]           err_code
);
    localparam int unsigned IW = $clog2(CLEAR_LEN);

    function automatic int unsigned depth_of(input logic [2:0] sel);
        int unsigned d;
        d = 0;
        case (sel)
            SEL_L0K0, SEL_L0K1: d = L0_DEPTH;
            SEL_L1K0, SEL_L1K1: d = L1_DEPTH;
            SEL_L2F:            d = L2_DEPTH;
            default:            d = 0;
        endcase
        return d;
    endfunction

    function automatic logic addr_ok(input logic [2:0] sel, input logic [AW-1:0] addr);
        return 32'(addr) < depth_of(sel);
    endfunction

    cic_state_e           state_reg, state_next;
    logic [IW-1:0]        clr_idx_reg, clr_idx_next;
    logic                 run, cnt_en, gnt, hs_ok;
    logic                 wr_sel_ok, wr_addr_ok, rd_addr_ok;
    cic_err_e             cause;
    logic                 err_reg;
    cic_err_e             err_code_reg;
    logic                 rd_ok_reg, h_valid_reg, h_ok_reg;
    logic [2:0]           rd_sel_reg, h_sel_reg;
    logic [DW-1:0]        bank_rd [NUM_BANKS];
    logic [DW-1:0]        bank_hd [NUM_BANKS];
    logic [NUM_BANKS-1:0] full_vec;
    logic [DW-1:0]        cdata_mux, hdata_mux;

    assign run        = (state_reg == ST_RUN);
    assign cnt_en     = run & ~h_clr;
    assign wr_sel_ok  = sel_legal(bus.csel);
    assign wr_addr_ok = addr_ok(bus.csel, bus.caddr_wr);
    assign rd_addr_ok = addr_ok(bus.csel, bus.caddr_rd);
    // The engine always wins; the host is also held off while clearing.
    assign gnt        = bus.h_req & ~bus.crd & ~bus.cwr & run;
    assign hs_ok      = sel_legal(bus.h_sel) & addr_ok(bus.h_sel, bus.h_addr);

    // Tracking state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    // Sweep every written-bit index once, then run; h_clr restarts the sweep.
    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_idx_next = clr_idx_reg + IW'(1);
                if (clr_idx_reg == IW'(CLEAR_LEN - 1)) state_next = ST_RUN;
            end
            default: ;
        endcase
        if (h_clr) begin
            state_next   = ST_CLEAR;
            clr_idx_next = '0;
        end
    end

    // Classify this cycle's protocol error; write causes outrank read causes.
    always_comb begin
        cause = ERR_NONE;
        if (bus.cwr && !wr_sel_ok)       cause = ERR_WR_SEL;
        else if (bus.cwr && !wr_addr_ok) cause = ERR_WR_ADDR;
        else if (bus.crd && !wr_sel_ok)  cause = ERR_RD_SEL;
        else if (bus.crd && !rd_addr_ok) cause = ERR_RD_ADDR;
    end

    // Sticky error flag holding only the first cause.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else if (h_clr) begin
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else if (!err_reg && cause != ERR_NONE) begin
            err_reg      <= 1'b1;
            err_code_reg <= cause;
        end
    end

    // Remember which bank each read targeted so the bank output can be steered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ok_reg   <= 1'b0;
            rd_sel_reg  <= '0;
            h_valid_reg <= 1'b0;
            h_ok_reg    <= 1'b0;
            h_sel_reg   <= '0;
        end else begin
            if (bus.crd) begin
                rd_ok_reg  <= wr_sel_ok & rd_addr_ok;
                rd_sel_reg <= bus.csel;
            end
            h_valid_reg <= gnt;
            if (gnt) begin
                h_ok_reg  <= hs_ok;
                h_sel_reg <= bus.h_sel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam int unsigned DEPTH = (gi < 2) ? L0_DEPTH : (gi < 4) ? L1_DEPTH : L2_DEPTH;
            localparam int unsigned BW    = $clog2(DEPTH);
            localparam logic [2:0]  SEL   = 3'(gi + 1);

            logic clr_en, wr_en, rd_en, hrd_en;
            assign clr_en = ~run & (32'(clr_idx_reg) < DEPTH);
            assign wr_en  = bus.cwr & (bus.csel == SEL) & wr_addr_ok;
            assign rd_en  = bus.crd & (bus.csel == SEL) & rd_addr_ok;
            assign hrd_en = gnt & (bus.h_sel == SEL) & hs_ok;

            cic_bank #(.DW(DW), .DEPTH(DEPTH)) u_bank (
                .clk      (clk),
                .reset    (reset),
                .run      (run),
                .clr_en   (clr_en),
                .clr_idx  (clr_idx_reg[BW-1:0]),
                .cnt_clr  (h_clr),
                .cnt_en   (cnt_en),
                .wr_en    (wr_en),
                .wr_addr  (bus.caddr_wr[BW-1:0]),
                .wr_data  (bus.cdata_wr),
                .rd_en    (rd_en),
                .rd_addr  (bus.caddr_rd[BW-1:0]),
                .rd_data  (bank_rd[gi]),
                .hrd_en   (hrd_en),
                .hrd_addr (bus.h_addr[BW-1:0]),
                .hrd_data (bank_hd[gi]),
                .full     (full_vec[gi])
            );
        end
    endgenerate

    // Steer bank outputs; illegal accesses read as zero.
    always_comb begin
        cdata_mux = '0;
        hdata_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_ok_reg && rd_sel_reg == 3'(i + 1)) cdata_mux = bank_rd[i];
            if (h_valid_reg && h_ok_reg && h_sel_reg == 3'(i + 1)) hdata_mux = bank_hd[i];
        end
    end

    assign bus.cdata_rd = cdata_mux;
    assign bus.h_gnt    = gnt;
    assign bus.h_valid  = h_valid_reg;
    assign bus.h_data   = hdata_mux;
    assign bank_full    = full_vec;
    assign all_full     = &full_vec;
    assign err          = err_reg;
    assign err_code     = err_code_reg;

endmodule

// File: tb/tb_cic_result_mem.sv
// Directed bench for the result memory: a vector table for the engine port
// plus hand sequences for fill, arbitration, clear, reset and error priority.
module tb_cic_result_mem;
    import cic_result_mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       h_clr;
    logic [4:0] bank_full;
    logic       all_full;
    logic       err;
    logic [2:0] err_code;
    int         checks = 0;
    int         errors = 0;

    cic_result_mem_if bus ();

    cic_result_mem dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .h_clr     (h_clr),
        .bank_full (bank_full),
        .all_full  (all_full),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cwr;
        logic        crd;
        logic [2:0]  csel;
        logic [11:0] waddr;
        logic [19:0] wdata;
        logic [11:0] raddr;
        logic        chk_rd;
        logic [19:0] exp_rd;
        logic        exp_err;
        logic [2:0]  exp_code;
    } vec_t;

    typedef struct {
        logic        w;
        logic        r;
        logic [2:0]  sel;
        logic [11:0] wa;
        logic [11:0] ra;
        logic [2:0]  code;
    } err_t;

    vec_t vecs [18];
    err_t ecase [4];

    function automatic logic [19:0] pat(input logic [2:0] sel, input int a);
        logic [31:0] v;
        v = ((32'(sel) << 12) | 32'(a)) ^ 32'h000A5A5A;
        return v[19:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic eng(input logic w, input logic r, input logic [2:0] sel,
                       input logic [11:0] wa, input logic [19:0] wd, input logic [11:0] ra);
        bus.cwr      = w;
        bus.crd      = r;
        bus.csel     = sel;
        bus.caddr_wr = wa;
        bus.cdata_wr = wd;
        bus.caddr_rd = ra;
    endtask

    task automatic fill(input logic [2:0] sel, input int depth);
        for (int a = 0; a < depth; a++) begin
            eng(1'b1, 1'b0, sel, 12'(a), pat(sel, a), 12'd0);
            tick();
        end
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
    endtask

    initial begin
        //            cwr   crd   csel  waddr     wdata       raddr     chk   exp_rd      err   code
        vecs[0]  = '{1'b1, 1'b0, 3'd1, 12'h123,  20'hABCDE, 12'h000,  1'b1, 20'h00000, 1'b0, 3'd0};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 12'h000,  20'h00000, 12'h123,  1'b1, 20'hABCDE, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 12'h000,  20'h00000, 12'h000,  1'b1, 20'hABCDE, 1'b0, 3'd0};
        vecs[3]  = '{1'b1, 1'b0, 3'd5, 12'd7,    20'h00011, 12'h000,  1'b1, 20'hABCDE, 1'b0, 3'd0};
        vecs[4]  = '{1'b1, 1'b1, 3'd5, 12'd7,    20'h00022, 12'd7,    1'b1, 20'h00011, 1'b0, 3'd0};
        vecs[5]  = '{1'b0, 1'b1, 3'd5, 12'h000,  20'h00000, 12'd7,    1'b1, 20'h00022, 1'b0, 3'd0};
        vecs[6]  = '{1'b1, 1'b0, 3'd3, 12'd3,    20'h12345, 12'h000,  1'b0, 20'h00000, 1'b0, 3'd0};
        vecs[7]  = '{1'b0, 1'b1, 3'd3, 12'h000,  20'h00000, 12'd3,    1'b1, 20'h12345, 1'b0, 3'd0};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 12'd4095, 20'hFFFFF, 12'h000,  1'b0, 20'h00000, 1'b0, 3'd0};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 12'h000,  20'h00000, 12'd4095, 1'b1, 20'hFFFFF, 1'b0, 3'd0};
        vecs[10] = '{1'b1, 1'b0, 3'd4, 12'd10,   20'h55555, 12'h000,  1'b0, 20'h00000, 1'b0, 3'd0};
        vecs[11] = '{1'b1, 1'b0, 3'd4, 12'd11,   20'h0AAAA, 12'h000,  1'b0, 20'h00000, 1'b0, 3'd0};
        vecs[12] = '{1'b1, 1'b1, 3'd4, 12'd10,   20'h66666, 12'd11,   1'b1, 20'h0AAAA, 1'b0, 3'd0};
        vecs[13] = '{1'b0, 1'b1, 3'd4, 12'h000,  20'h00000, 12'd10,   1'b1, 20'h66666, 1'b0, 3'd0};
        vecs[14] = '{1'b1, 1'b0, 3'd0, 12'h123,  20'h11111, 12'h000,  1'b1, 20'h66666, 1'b1, 3'd1};
        vecs[15] = '{1'b0, 1'b1, 3'd3, 12'h000,  20'h00000, 12'd1024, 1'b1, 20'h00000, 1'b1, 3'd1};
        vecs[16] = '{1'b0, 1'b1, 3'd1, 12'h000,  20'h00000, 12'h123,  1'b1, 20'hABCDE, 1'b1, 3'd1};
        vecs[17] = '{1'b0, 1'b1, 3'd6, 12'h000,  20'h00000, 12'h000,  1'b1, 20'h00000, 1'b1, 3'd1};

        //            w     r     sel   wa        ra        code
        ecase[0] = '{1'b0, 1'b1, 3'd7, 12'd0,    12'd0,    3'd3};
        ecase[1] = '{1'b0, 1'b1, 3'd5, 12'd0,    12'd2048, 3'd4};
        ecase[2] = '{1'b1, 1'b1, 3'd3, 12'd1024, 12'd2000, 3'd2};
        ecase[3] = '{1'b1, 1'b1, 3'd6, 12'd0,    12'd0,    3'd1};

        reset = 1'b1;
        h_clr = 1'b0;
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
        bus.h_req  = 1'b0;
        bus.h_sel  = 3'd0;
        bus.h_addr = 12'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        bus.h_req = 1'b1;
        #1;
        chk("rst_cdata_rd", bus.cdata_rd, 0);
        chk("rst_h_gnt", bus.h_gnt, 0);
        chk("rst_h_valid", bus.h_valid, 0);
        chk("rst_h_data", bus.h_data, 0);
        chk("rst_bank_full", bank_full, 0);
        chk("rst_all_full", all_full, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        bus.h_req = 1'b0;
        reset = 1'b0;

        // Host is locked out while the written bits are being swept
        repeat (10) tick();
        bus.h_req = 1'b1;
        #1;
        chk("gnt_during_clear", bus.h_gnt, 0);
        bus.h_req = 1'b0;
        repeat (4100) tick();

        // Engine port vector table
        for (int i = 0; i < 18; i++) begin
            eng(vecs[i].cwr, vecs[i].crd, vecs[i].csel, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
            tick();
            $display("vec %0d: cwr=%b crd=%b csel=%0d -> cdata_rd=0x%05h err=%b err_code=%0d",
                     i, vecs[i].cwr, vecs[i].crd, vecs[i].csel, bus.cdata_rd, err, err_code);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_cdata_rd", i), bus.cdata_rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_err_code", i), err_code, vecs[i].exp_code);
        end
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);

        // Fill L1K1; full flag follows the last new address, rewrite leaves it alone
        for (int a = 0; a < 1024; a++) begin
            eng(1'b1, 1'b0, 3'd4, 12'(a), pat(3'd4, a), 12'd0);
            if (a == 1023) chk("full_before_last", bank_full, 0);
            tick();
        end
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
        tick();
        chk("l1k1_full", bank_full, 5'b01000);
        chk("l1k1_all_full", all_full, 0);
        eng(1'b1, 1'b0, 3'd4, 12'd5, pat(3'd4, 5), 12'd0);
        tick();
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
        repeat (2) tick();
        chk("full_after_rewrite", bank_full, 5'b01000);
        $display("fill L1K1: bank_full=%b all_full=%b", bank_full, all_full);

        // Fill every other bank
        fill(3'd1, 4096);
        fill(3'd2, 4096);
        fill(3'd3, 1024);
        fill(3'd5, 2048);
        repeat (2) tick();
        chk("all_bank_full", bank_full, 5'b11111);
        chk("all_full", all_full, 1);
        $display("fill all: bank_full=%b all_full=%b", bank_full, all_full);

        // Host request held while the engine reads for two cycles
        bus.h_req  = 1'b1;
        bus.h_sel  = 3'd5;
        bus.h_addr = 12'd100;
        for (int c = 0; c < 2; c++) begin
            eng(1'b0, 1'b1, 3'd5, 12'd0, 20'd0, 12'd7);
            #1;
            chk($sformatf("arb_gnt_c%0d", c), bus.h_gnt, 0);
            tick();
            chk($sformatf("arb_valid_c%0d", c), bus.h_valid, 0);
            chk($sformatf("arb_cdata_c%0d", c), bus.cdata_rd, pat(3'd5, 7));
        end
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
        #1;
        chk("arb_gnt_c2", bus.h_gnt, 1);
        tick();
        bus.h_req = 1'b0;
        chk("arb_valid_c3", bus.h_valid, 1);
        chk("arb_data_c3", bus.h_data, pat(3'd5, 100));
        $display("host read L2F[100]: h_valid=%b h_data=0x%05h", bus.h_valid, bus.h_data);
        tick();
        chk("arb_valid_c4", bus.h_valid, 0);

        // h_clr drops tracking but keeps data
        h_clr = 1'b1;
        tick();
        h_clr = 1'b0;
        chk("clr_bank_full", bank_full, 0);
        chk("clr_all_full", all_full, 0);
        chk("clr_err", err, 0);
        chk("clr_err_code", err_code, 0);
        bus.h_req = 1'b1;
        bus.h_sel = 3'd1;
        #1;
        chk("clr_gnt_blocked", bus.h_gnt, 0);
        bus.h_req = 1'b0;
        repeat (4100) tick();
        chk("post_clear_full", bank_full, 0);
        chk("post_clear_err", err, 0);
        eng(1'b0, 1'b1, 3'd1, 12'd0, 20'd0, 12'h123);
        tick();
        chk("keep_l0k0", bus.cdata_rd, pat(3'd1, 12'h123));
        eng(1'b0, 1'b1, 3'd5, 12'd0, 20'd0, 12'd2047);
        tick();
        chk("keep_l2f", bus.cdata_rd, pat(3'd5, 2047));
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);

        // Written bits were really swept: refilling L1K0 counts from zero
        fill(3'd3, 1024);
        repeat (2) tick();
        chk("refill_l1k0", bank_full, 5'b00100);

        // Illegal host accesses return zero without raising an error
        bus.h_req  = 1'b1;
        bus.h_sel  = 3'd0;
        bus.h_addr = 12'd5;
        #1;
        chk("hill_gnt", bus.h_gnt, 1);
        tick();
        chk("hill_valid", bus.h_valid, 1);
        chk("hill_data", bus.h_data, 0);
        bus.h_sel  = 3'd3;
        bus.h_addr = 12'd1024;
        tick();
        bus.h_req = 1'b0;
        chk("hrange_valid", bus.h_valid, 1);
        chk("hrange_data", bus.h_data, 0);
        chk("hill_err", err, 0);

        // Reset with a host result in flight; memory persists
        bus.h_req  = 1'b1;
        bus.h_sel  = 3'd5;
        bus.h_addr = 12'd3;
        tick();
        bus.h_req = 1'b0;
        chk("inflight_valid", bus.h_valid, 1);
        chk("inflight_data", bus.h_data, pat(3'd5, 3));
        reset = 1'b1;
        #1;
        chk("midrst_valid", bus.h_valid, 0);
        chk("midrst_data", bus.h_data, 0);
        tick();
        reset = 1'b0;
        eng(1'b0, 1'b1, 3'd5, 12'd0, 20'd0, 12'd3);
        tick();
        chk("midrst_mem_kept", bus.cdata_rd, pat(3'd5, 3));
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);

        // Each error cause in isolation, and write-over-read priority
        for (int i = 0; i < 4; i++) begin
            h_clr = 1'b1;
            tick();
            h_clr = 1'b0;
            chk($sformatf("ecase%0d_cleared", i), err, 0);
            eng(ecase[i].w, ecase[i].r, ecase[i].sel, ecase[i].wa, 20'h12345, ecase[i].ra);
            tick();
            eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
            chk($sformatf("ecase%0d_err", i), err, 1);
            chk($sformatf("ecase%0d_code", i), err_code, ecase[i].code);
            $display("error case %0d: err=%b err_code=%0d", i, err, err_code);
        end
        // A later cause does not overwrite the first
        eng(1'b0, 1'b1, 3'd5, 12'd0, 20'd0, 12'd2048);
        tick();
        eng(1'b0, 1'b0, 3'd0, 12'd0, 20'd0, 12'd0);
        chk("sticky_code", err_code, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_result_mem.md
Name: cic_result_mem

Overview:
- Responder for the CONV engine's result-memory interface (csel/cwr/crd/caddr/cdata).
- Holds five result banks: L0K0, L0K1, L1K0, L1K1, L2F.
- Services engine writes and reads, and tracks per-bank fill and protocol errors.
- Gives the verification host a stall-able readback port to dump results after the engine finishes.

Parameters:
- DW, 20, data width, matches cdata_rd/cdata_wr
- AW, 12, address width
- L0_DEPTH, 4096, words in L0K0 and L0K1 (64x64)
- L1_DEPTH, 1024, words in L1K0 and L1K1 (32x32 after max-pool)
- L2_DEPTH, 2048, words in L2F (interleaved flatten)

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- csel  in  3  bank select: 0 NSEL, 1 L0K0, 2 L0K1, 3 L1K0, 4 L1K1, 5 L2F, 6-7 illegal
- cwr  in  1  engine write enable
- caddr_wr  in  AW  engine write address
- cdata_wr  in  DW  engine write data
- crd  in  1  engine read enable
- caddr_rd  in  AW  engine read address
- cdata_rd  out  DW  engine read data
- h_req  in  1  host read request
- h_sel  in  3  host bank select, same encoding as csel
- h_addr  in  AW  host read address
- h_gnt  out  1  host request accepted this cycle
- h_valid  out  1  h_data valid
- h_data  out  DW  host read data
- h_clr  in  1  clear fill/error tracking (not data)
- bank_full  out  5  bit n-1 set when every address of bank n has been written at least once
- all_full  out  1  AND of bank_full
- err  out  1  sticky protocol error
- err_code  out  3  first error cause: 1 write NSEL/illegal sel, 2 write addr >= depth, 3 read NSEL/illegal sel, 4 read addr >= depth

Behaviour:
- Reset: cdata_rd=0, h_gnt=0, h_valid=0, h_data=0, bank_full=0, all_full=0, err=0, err_code=0. Written-bit vectors are cleared; bank contents are not.
- Engine write: sampled at a rising edge when cwr=1. Legal csel and caddr_wr < depth → word stored and the address's written bit set. Otherwise the write is dropped and the error is flagged.
- Engine read: crd=1 at edge N → cdata_rd = mem[csel][caddr_rd] after edge N (1-cycle latency). cdata_rd holds its last value while crd=0. An illegal read returns 0 and flags the error.
- cwr and crd together, same bank, same address: read-before-write, so cdata_rd returns the old word. Different addresses are independent. cwr and crd may use different csel only through the shared csel, so both act on the same bank.
- Fill counter: one per bank, incremented only on the first write to an address (written bit was 0). bank_full[n] asserts on the cycle after the counter reaches depth. Rewriting an address changes neither counter nor flag.
- Host port:
  - Arbitration, same cycle: h_gnt = h_req & ~crd & ~cwr. The engine always wins.
  - h_gnt=1 at edge N → h_valid=1 and h_data = mem[h_sel][h_addr] after edge N. h_valid is a single-cycle pulse per grant.
  - The host holds h_req/h_sel/h_addr stable until granted.
  - Illegal host access → h_data=0, h_valid=1, no error flagged.
- err is sticky. err_code latches only the first cause. When two causes occur in one cycle, write causes take priority.
- h_clr=1: next cycle clears all written bits, counters, bank_full, all_full, err and err_code. An engine write in the same cycle as h_clr is stored but not counted.
- Reset mid-operation: an in-flight read result is discarded, h_valid=0. Memory contents persist.
- Internal state machine, tracking only (CLEAR / RUN):
  - CLEAR iterates the written-bit vectors after reset or h_clr, one index per cycle per bank, max depth 4096 cycles.
  - During CLEAR: engine writes and reads are serviced normally, but writes are not counted; host requests are not granted.
  - CLEAR → RUN when the index wraps at 4096.
  - bank_full and all_full are forced to 0 during CLEAR.

Decomposition:
- Shared package: csel encodings (NSEL, L0K0, L0K1, L1K0, L1K1, L2F), bank depth constants, err_code constants. The engine uses the same package.
- One sub-module, cic_bank: a single-port-write, two-read-port RAM of parameterised depth holding its own written-bit vector and fill counter. Instantiated five times.
- The top level holds decode, arbitration, error logic and the CLEAR/RUN FSM.

Test Plan:
- Reset, wait 4096 cycles for CLEAR to finish, then write 0xABCDE to L0K0 addr 0x123; read the same address next cycle → cdata_rd=0xABCDE one cycle after crd; err=0.
- Write all 1024 addresses of L1K1 once, then rewrite addr 5 → bank_full=5'b01000 from the cycle after the 1024th write; rewrite leaves it unchanged; all_full=0.
- Write with csel=0, then read L1K0 addr 1024 → err=1, err_code=1 (first cause retained); data memory unchanged.
- Same-cycle cwr+crd on L2F addr 7 (old 0x00011, new 0x00022) → cdata_rd=0x00011; next read returns 0x00022.
- h_req held 3 cycles while crd=1 for 2 of them → h_gnt only in cycle 3; h_valid pulses once in cycle 4 with the correct word.
- Fill all banks (all_full=1), pulse h_clr → after CLEAR completes, bank_full=0, err=0, and data reads return the previous values.
